// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared decode, MMIO map and status-bit definitions for the CPU data bus
package cpu_bus_pkg;

    // Word offsets of the MMIO registers relative to MMIO_BASE
    localparam logic [1:0] MMIO_GPIO    = 2'd0;
    localparam logic [1:0] MMIO_COUNT   = 2'd1;
    localparam logic [1:0] MMIO_COMPARE = 2'd2;
    localparam logic [1:0] MMIO_STATUS  = 2'd3;

    // STATUS register bit positions
    localparam int ST_IRQ     = 0;
    localparam int ST_ERR_LSB = 8;
    localparam int ST_ERR_CLR = 31;

    // COMPARE starts at the top of the range so it cannot match soon after reset
    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_e;

endpackage

// File: rtl/data_ram.sv
// data_ram: single-port synchronous word RAM with registered read, no reset
module data_ram #(
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [RAM_AW-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**RAM_AW];
    logic [31:0] rdata_q;

    // Write on we; the read register only updates on re so the output holds between reads
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_bus_unit.sv
// data_bus_unit: CPU data-bus slave decoding accesses into data RAM or an MMIO register bank
module data_bus_unit
    import cpu_bus_pkg::*;
#(
    parameter int          RAM_AW    = 10,
    parameter logic [31:0] MMIO_BASE = 32'h0000_0400,
    parameter int          GPIO_W    = 8
) (
    input  logic              CLK,
    input  logic              Rst,
    input  logic              CS,
    input  logic              WR_RD,
    input  logic [31:0]       ADDR,
    input  logic [31:0]       Data_BUS_WRITE,
    output logic [31:0]       Data_BUS_READ,
    output logic              RD_VALID,
    output logic [GPIO_W-1:0] GPIO_OUT,
    output logic              IRQ,
    output logic              BUS_ERR
);

    localparam logic [31:0] RAM_WORDS = 32'(2**RAM_AW);

    logic [31:0]       count_q, count_d;
    logic [31:0]       compare_q, compare_d;
    logic [31:0]       mmio_rdata_q, mmio_rdata_d;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              irq_q, irq_d;
    logic              rd_valid_q, rd_valid_d;
    logic              bus_err_q, bus_err_d;
    region_e           src_q, src_d;

    region_e     region;
    logic [1:0]  off;
    logic        acc, wr, rd, err, mmio_wr, ram_we, ram_re;
    logic [31:0] mmio_val, ram_rdata;

    // Address decode and access qualification; reset discards any access in flight
    always_comb begin
        acc      = CS & ~Rst;
        wr       = acc & WR_RD;
        rd       = acc & ~WR_RD;
        region   = ADDR < RAM_WORDS ? REG_RAM :
                   (ADDR >= MMIO_BASE && ADDR - MMIO_BASE < 32'd4) ? REG_MMIO : REG_NONE;
        off      = 2'(ADDR - MMIO_BASE);
        err      = acc & (region == REG_NONE);
        mmio_wr  = wr & (region == REG_MMIO);
        ram_we   = wr & (region == REG_RAM);
        ram_re   = rd & (region == REG_RAM);
        mmio_val = off == MMIO_GPIO    ? 32'(gpio_q) :
                   off == MMIO_COUNT   ? count_q :
                   off == MMIO_COMPARE ? compare_q :
                   32'(irq_q) << ST_IRQ | 32'(err_cnt_q) << ST_ERR_LSB;
    end

    // Next state of the MMIO bank; a COUNT write beats the increment, a match beats W1C
    always_comb begin
        gpio_d       = mmio_wr && off == MMIO_GPIO ? Data_BUS_WRITE[GPIO_W-1:0] : gpio_q;
        count_d      = mmio_wr && off == MMIO_COUNT ? Data_BUS_WRITE : count_q + 32'd1;
        compare_d    = mmio_wr && off == MMIO_COMPARE ? Data_BUS_WRITE : compare_q;
        irq_d        = (count_q == compare_q) |
                       (irq_q & ~(mmio_wr && off == MMIO_STATUS && Data_BUS_WRITE[ST_IRQ]));
        err_cnt_d    = mmio_wr && off == MMIO_STATUS && Data_BUS_WRITE[ST_ERR_CLR] ? 8'd0 :
                       err && err_cnt_q != 8'hFF ? err_cnt_q + 8'd1 : err_cnt_q;
        rd_valid_d   = rd;
        bus_err_d    = err;
        src_d        = rd ? region : src_q;
        mmio_rdata_d = rd ? (region == REG_MMIO ? mmio_val : 32'd0) : mmio_rdata_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (Rst) begin
            count_q      <= 32'd0;
            compare_q    <= COMPARE_RST;
            mmio_rdata_q <= 32'd0;
            gpio_q       <= '0;
            err_cnt_q    <= 8'd0;
            irq_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            src_q        <= REG_NONE;
        end else begin
            count_q      <= count_d;
            compare_q    <= compare_d;
            mmio_rdata_q <= mmio_rdata_d;
            gpio_q       <= gpio_d;
            err_cnt_q    <= err_cnt_d;
            irq_q        <= irq_d;
            rd_valid_q   <= rd_valid_d;
            bus_err_q    <= bus_err_d;
            src_q        <= src_d;
        end
    end

    data_ram #(.RAM_AW(RAM_AW)) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ADDR[RAM_AW-1:0]),
        .wdata (Data_BUS_WRITE),
        .rdata (ram_rdata)
    );

    // Read data comes from whichever registered source the last read selected
    assign Data_BUS_READ = src_q == REG_RAM ? ram_rdata : mmio_rdata_q;
    assign RD_VALID      = rd_valid_q;
    assign GPIO_OUT      = gpio_q;
    assign IRQ           = irq_q;
    assign BUS_ERR       = bus_err_q;

endmodule

// File: tb/tb_data_bus_unit.sv
// tb_data_bus_unit: scoreboard bench for data_bus_unit
module tb_data_bus_unit;
    localparam logic [31:0] B = 32'h0000_0400;

    logic        CLK = 0, Rst = 1, CS = 0, WR_RD = 0;
    logic [31:0] ADDR = 0, Data_BUS_WRITE = 0, Data_BUS_READ;
    logic        RD_VALID, IRQ, BUS_ERR;
    logic [7:0]  GPIO_OUT;
    logic [31:0] sb[$];
    logic [31:0] words[4];
    int          n_tests = 0, n_fail = 0;

    data_bus_unit dut (
        .CLK(CLK), .Rst(Rst), .CS(CS), .WR_RD(WR_RD), .ADDR(ADDR),
        .Data_BUS_WRITE(Data_BUS_WRITE), .Data_BUS_READ(Data_BUS_READ),
        .RD_VALID(RD_VALID), .GPIO_OUT(GPIO_OUT), .IRQ(IRQ), .BUS_ERR(BUS_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d);
        CS = 1; WR_RD = w; ADDR = a; Data_BUS_WRITE = d;
        @(posedge CLK); #1;
        CS = 0; WR_RD = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        acc(1, a, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        sb.push_back(e);
        acc(0, a, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    always @(negedge CLK)
        if (RD_VALID) begin
            if (sb.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", Data_BUS_READ, sb.pop_front());
        end

    initial begin
        idle(2);
        chk("rst_rdata", Data_BUS_READ, 0);
        chk("rst_rvalid", 32'(RD_VALID), 0);
        chk("rst_gpio", 32'(GPIO_OUT), 0);
        chk("rst_irq", 32'(IRQ), 0);
        chk("rst_berr", 32'(BUS_ERR), 0);
        Rst = 0;
        wr(5, 32'h1DAA);
        rd(5, 32'h0000_1DAA);
        chk("rv_pulse", 32'(RD_VALID), 1);
        idle(1);
        chk("rv_drop", 32'(RD_VALID), 0);
        wr(6, 32'h1234);
        idle(1);
        chk("rd_hold", Data_BUS_READ, 32'h0000_1DAA);
        wr(9, 32'hCAFE_0009);
        rd(9, 32'hCAFE_0009);
        for (int i = 0; i < 4; i++) begin
            words[i] = $urandom;
            wr(32'h3FC + i, words[i]);
        end
        for (int i = 0; i < 4; i++) rd(32'h3FC + i, words[i]);
        wr(B, 32'hFFFF_FFA5);
        chk("gpio", 32'(GPIO_OUT), 32'hA5);
        rd(B, 32'h0000_00A5);
        rd(B + 2, 32'hFFFF_FFFF);
        idle(1);
        rd(32'h0000_2000, 0);
        chk("berr_pulse", 32'(BUS_ERR), 1);
        idle(1);
        chk("berr_drop", 32'(BUS_ERR), 0);
        rd(B + 3, 32'h0000_0100);
        for (int i = 0; i < 300; i++) wr(B + 4 + i, 32'hFFFF_FFFF);
        rd(B + 3, 32'h0000_FF00);
        wr(B + 3, 32'h8000_0000);
        rd(B + 3, 0);
        wr(B + 1, 32'h100);
        wr(B + 2, 10);
        wr(B + 3, 1);
        wr(B + 1, 5);
        for (int i = 1; i <= 6; i++) begin
            @(posedge CLK); #1;
            chk("irq_rise", 32'(IRQ), 32'(i == 6));
        end
        idle(3);
        chk("irq_sticky", 32'(IRQ), 1);
        wr(B + 3, 1);
        chk("irq_w1c", 32'(IRQ), 0);
        wr(B + 1, 8);
        idle(2);
        chk("irq_pre", 32'(IRQ), 0);
        wr(B + 3, 1);
        chk("irq_set_wins", 32'(IRQ), 1);
        wr(B + 1, 32'hFFFF_FFFE);
        idle(3);
        rd(B + 1, 1);
        idle(1);
        wr(7, 32'h77);
        wr(B, 32'h3C);
        rd(5, 32'h0000_1DAA);
        Rst = 1; CS = 1; WR_RD = 1; ADDR = 7; Data_BUS_WRITE = 32'hDEAD_BEEF;
        @(posedge CLK); #1;
        WR_RD = 0;
        @(posedge CLK); #1;
        CS = 0; Rst = 0;
        chk("rst2_rdata", Data_BUS_READ, 0);
        chk("rst2_rvalid", 32'(RD_VALID), 0);
        chk("rst2_gpio", 32'(GPIO_OUT), 0);
        chk("rst2_irq", 32'(IRQ), 0);
        chk("rst2_berr", 32'(BUS_ERR), 0);
        rd(7, 32'h77);
        rd(B + 2, 32'hFFFF_FFFF);
        idle(2);
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_bus_unit.md
# data_bus_unit

Slave end of the CPU external data bus: consumes `CS`, `WR_RD`, `ADDR` and `Data_BUS_WRITE` from `cpu` and drives `Data_BUS_READ` back to it. It decodes each access into either a single-port data RAM or a small memory-mapped I/O (MMIO) register bank. The MMIO bank holds a GPIO output register, a free-running cycle counter with compare interrupt, and a status register. In the system top it replaces the constant read-bus stimulus and sits directly downstream of `cpu`.

## Interface
Parameters:
- `RAM_AW`, 10: RAM word-address width; `2**RAM_AW` 32-bit words.
- `MMIO_BASE`, 32'h0000_0400: word address of MMIO register 0.
- `GPIO_W`, 8: GPIO output width.

Ports:
- `CLK` in 1: the only clock; all state updates on the rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `CS` in 1: access strobe; one access per cycle in which it is high.
- `WR_RD` in 1: 1 = write, 0 = read; qualified by `CS`.
- `ADDR` in 32: word address.
- `Data_BUS_WRITE` in 32: write data.
- `Data_BUS_READ` out 32: registered read data.
- `RD_VALID` out 1: one-cycle pulse, `Data_BUS_READ` updated this cycle.
- `GPIO_OUT` out `GPIO_W`: GPIO register.
- `IRQ` out 1: sticky compare-match flag.
- `BUS_ERR` out 1: one-cycle pulse on an unmapped access.

## Operation
Address decode:
- RAM: `ADDR < 2**RAM_AW`.
- MMIO: `MMIO_BASE` to `MMIO_BASE+3`.
- Anything else is unmapped.
- `MMIO_BASE` must be at least `2**RAM_AW`; regions never overlap.

MMIO register map (offset from `MMIO_BASE`):
- 0 GPIO: R/W, low `GPIO_W` bits; upper read bits are 0.
- 1 COUNT: R/W; increments by 1 every cycle and wraps from FFFF_FFFF to 0. A write loads the written value, and the write wins over that cycle's increment.
- 2 COMPARE: R/W; reset value FFFF_FFFF.
- 3 STATUS: bit0 = IRQ flag, write-1-to-clear. Bits[15:8] = unmapped-access count, saturating at 255; a write with bit 31 set clears the count. Other bits read 0.

Access behaviour:
- Write (`CS & WR_RD`): target updated at that edge. An unmapped write is dropped and raises `BUS_ERR`.
- Read (`CS & ~WR_RD`): target sampled at that edge, presented on `Data_BUS_READ` in the next cycle, with `RD_VALID` high for that one cycle. `Data_BUS_READ` then holds until the next read.
- An unmapped read returns 0, raises `BUS_ERR` and also asserts `RD_VALID`.
- A read of COUNT returns its pre-increment value at the sampling edge.

IRQ:
- At each edge where the current COUNT equals COMPARE, the IRQ flag sets; `IRQ` follows the flag.
- If a STATUS W1C write and a match occur in the same cycle, set wins.

## Timing
- Read latency is 1 cycle, fixed, with no wait states; `cpu` needs no ready signal.
- Back-to-back accesses are allowed every cycle.
- A read in the cycle after a write to the same address returns the new data (RAM is write-then-read safe across cycles).
- `CS` low means no state changes except the COUNT increment and the IRQ match check.
- Reset values:
  - `Data_BUS_READ` = 0, `RD_VALID` = 0, `BUS_ERR` = 0, `GPIO_OUT` = 0, `IRQ` = 0.
  - COUNT = 0, COMPARE = FFFF_FFFF, error count = 0.
  - RAM contents are not reset.
- Reset asserted during an access discards it: no write, no `RD_VALID`. The first access is accepted in the cycle after `Rst` falls.
- Error count: increments once per unmapped access; held at 255 once reached.

## Structure
- Package `cpu_bus_pkg` holds:
  - MMIO offset constants (`MMIO_GPIO`, `MMIO_COUNT`, `MMIO_COMPARE`, `MMIO_STATUS`);
  - the decode-region enum (`REG_RAM`, `REG_MMIO`, `REG_NONE`);
  - STATUS bit positions;
  - the reset value of COMPARE.
- One sub-module, `data_ram`: single-port synchronous RAM with `RAM_AW` address bits, a 32-bit data port and a write enable. It has no reset; the read is registered inside it.
- The decode, MMIO bank and read mux stay in `data_bus_unit`.

## Test plan
- Write 0x1DAA to RAM address 5, then read address 5 -> next cycle `Data_BUS_READ` = 0000_1DAA, `RD_VALID` = 1 for exactly one cycle.
- Write 0xA5 to `MMIO_BASE+0` -> `GPIO_OUT` = 8'hA5 after that edge; reading back gives 0000_00A5.
- Write COMPARE = 10, then write COUNT = 5 -> `IRQ` rises 6 cycles after the COUNT write and stays high. A STATUS write of 1 clears it; a W1C issued in the match cycle leaves it set.
- Write COUNT = FFFF_FFFE, idle, then read COUNT -> wraps through 0 and returns the correct small value.
- Read address 0x0000_2000 -> `Data_BUS_READ` = 0, `BUS_ERR` pulses, STATUS[15:8] increments. After 300 unmapped accesses, STATUS[15:8] reads 255.
- Assert `Rst` in the same cycle as a RAM write to address 7 -> word 7 keeps its old value, `RD_VALID` stays 0, and all outputs take their reset values.
